// File: rtl/xover_biquad_engine.sv
// xover_biquad_engine: time-multiplexed LPF/HPF biquad cascade crossover sharing one multiplier/accumulator.
// Optional macro XOVER_SAT_EN adds output clamping and the sticky o_sat flag.
module xover_biquad_engine #(
   parameter int DATA_NBITS  = 24,
   parameter int COEFF_NBITS = 40,
   parameter int COEFF_FBITS = 36,
   parameter int ACCUM_NBITS = 72,
   parameter int NUM_CH      = 2,
   parameter int NUM_STAGES  = 2,
   parameter int CADDR_NBITS = 5
) (
   input  logic                         i_mck,
   input  logic                         i_rst,
   input  logic [NUM_CH*DATA_NBITS-1:0] i_data,
   input  logic                         i_sample_valid,
   output logic [NUM_CH*DATA_NBITS-1:0] o_lpf,
   output logic [NUM_CH*DATA_NBITS-1:0] o_hpf,
   output logic                         o_sample_valid,
   output logic                         o_busy,
   output logic                         o_overrun,
   input  logic                         i_coeff_we,
   input  logic [CADDR_NBITS-1:0]       i_coeff_addr,
   input  logic [COEFF_NBITS-1:0]       i_coeff_data,
   input  logic                         i_coeff_commit,
   input  logic                         i_clear_state
`ifdef XOVER_SAT_EN
   ,output logic                        o_sat
`endif
);
   localparam int D     = DATA_NBITS;
   localparam int C     = COEFF_NBITS;
   localparam int A     = ACCUM_NBITS;
   localparam int NCOEF = 10 * NUM_STAGES;
   localparam int NBQ   = NUM_CH * 2 * NUM_STAGES;
   localparam int SW    = NUM_STAGES > 1 ? $clog2(NUM_STAGES) : 1;
   localparam int CW    = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
   localparam int IW    = NBQ > 1 ? $clog2(NBQ) : 1;
   localparam int KW    = $clog2(NCOEF);
   localparam logic signed [A-1:0] SMAX = {{(A-D+1){1'b0}}, {(D-1){1'b1}}};
   localparam logic signed [A-1:0] SMIN = ~SMAX;

   typedef enum logic [1:0] {IDLE, RUN, FIN, OUT} state_t;
   state_t state, state_nx;

   logic [2:0]                 phase;
   logic [SW-1:0]              stg;
   logic                       band;
   logic [CW-1:0]              ch;
   logic signed [C-1:0]        shadow [NCOEF];
   logic signed [C-1:0]        active [NCOEF];
   logic signed [D-1:0]        x1 [NBQ];
   logic signed [D-1:0]        x2 [NBQ];
   logic signed [D-1:0]        y1 [NBQ];
   logic signed [D-1:0]        y2 [NBQ];
   logic [NUM_CH*D-1:0]        samp, lpf_res, hpf_res;
   logic signed [D-1:0]        yprev, xin, d_op, y;
   logic signed [C-1:0]        c_op;
   logic signed [D+C-1:0]      prod_raw;
   logic signed [A-1:0]        prod, prod_r, acc, sh;
   logic [IW-1:0]              bi;
   logic [KW-1:0]              ci;
   logic                       pend_commit, pend_clear, accept, last, do_commit, do_clear, stg_last;

   always_comb begin
      stg_last  = stg == SW'(NUM_STAGES - 1);
      last      = phase == 3'd6 && stg_last && band && ch == CW'(NUM_CH - 1);
      accept    = state == IDLE && i_sample_valid;
      do_commit = state == IDLE && (pend_commit || i_coeff_commit);
      do_clear  = state == IDLE && (pend_clear || i_clear_state);
      bi        = IW'((int'(ch) * 2 + int'(band)) * NUM_STAGES + int'(stg));
      ci        = KW'((int'(band) * NUM_STAGES + int'(stg)) * 5 + (phase > 3'd4 ? 0 : int'(phase)));
      xin       = stg == '0 ? samp[int'(ch)*D +: D] : yprev;
      d_op      = phase == 3'd0 ? xin : phase == 3'd1 ? x1[bi] : phase == 3'd2 ? x2[bi] :
                  phase == 3'd3 ? y1[bi] : y2[bi];
      c_op      = active[ci];
      prod_raw  = d_op * c_op;
      prod      = A'(prod_raw);
      sh        = acc >>> COEFF_FBITS;
`ifdef XOVER_SAT_EN
      y         = sh > SMAX ? SMAX[D-1:0] : sh < SMIN ? SMIN[D-1:0] : sh[D-1:0];
`else
      y         = {sh[A-1], sh[D-2:0]};
`endif
   end

`ifndef XOVER_SAT_EN
   logic unused_sh;
   assign unused_sh = ^{sh, SMIN, SMAX};
`endif

   always_comb begin
      state_nx = accept ? RUN : (state == RUN && last) ? FIN : state == FIN ? OUT :
                 state == OUT ? IDLE : state;
   end

   always_ff @(posedge i_mck) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nx;
   end

   assign o_busy         = state != IDLE;
   assign o_sample_valid = state == OUT;

   always_ff @(posedge i_mck) begin
      if (i_rst) begin
         phase       <= '0;
         stg         <= '0;
         band        <= 1'b0;
         ch          <= '0;
         samp        <= '0;
         yprev       <= '0;
         prod_r      <= '0;
         acc         <= '0;
         lpf_res     <= '0;
         hpf_res     <= '0;
         o_lpf       <= '0;
         o_hpf       <= '0;
         o_overrun   <= 1'b0;
         pend_commit <= 1'b0;
         pend_clear  <= 1'b0;
`ifdef XOVER_SAT_EN
         o_sat       <= 1'b0;
`endif
         for (int i = 0; i < NCOEF; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
         for (int i = 0; i < NBQ; i++) begin
            x1[i] <= '0;
            x2[i] <= '0;
            y1[i] <= '0;
            y2[i] <= '0;
         end
      end else begin
         if (i_coeff_we && int'(i_coeff_addr) < NCOEF) shadow[KW'(i_coeff_addr)] <= i_coeff_data;
         pend_commit <= state == IDLE ? 1'b0 : pend_commit | i_coeff_commit;
         pend_clear  <= state == IDLE ? 1'b0 : pend_clear | i_clear_state;
         if (do_commit)
            for (int i = 0; i < NCOEF; i++) active[i] <= shadow[i];
         if (do_clear)
            for (int i = 0; i < NBQ; i++) begin
               x1[i] <= '0;
               x2[i] <= '0;
               y1[i] <= '0;
               y2[i] <= '0;
            end
         if (i_sample_valid && o_busy) o_overrun <= 1'b1;
         if (accept) begin
            samp  <= i_data;
            phase <= '0;
            stg   <= '0;
            band  <= 1'b0;
            ch    <= '0;
         end
         if (state == RUN) begin
            prod_r <= prod;
            phase  <= phase == 3'd6 ? 3'd0 : phase + 3'd1;
            // phase 1 starts the sum; phases 2..3 add b-terms, 4..5 subtract a-terms
            if (phase != 3'd0 && phase != 3'd6)
               acc <= phase == 3'd1 ? prod_r : phase < 3'd4 ? acc + prod_r : acc - prod_r;
            if (phase == 3'd6) begin
               x1[bi] <= xin;
               x2[bi] <= x1[bi];
               y1[bi] <= y;
               y2[bi] <= y1[bi];
               yprev  <= y;
               stg    <= stg_last ? '0 : stg + 1'b1;
               if (stg_last) begin
                  if (band) lpf_res[int'(ch)*D +: D] <= y;
                  else      hpf_res[int'(ch)*D +: D] <= y;
                  band <= ~band;
                  if (band) ch <= ch + 1'b1;
               end
`ifdef XOVER_SAT_EN
               if (sh > SMAX || sh < SMIN) o_sat <= 1'b1;
`endif
            end
         end
         if (state == FIN) begin
            o_lpf <= lpf_res;
            o_hpf <= hpf_res;
         end
      end
   end
endmodule

// File: doc/xover_biquad_engine.md
Name: xover_biquad_engine

Overview:
- Parametrised, time-multiplexed cascaded-biquad crossover. Produces NUM_STAGES-deep LPF and HPF cascades for NUM_CH channels using one shared multiplier and accumulator.
- Sits between the I2S receive path and the band output serialisers.
- Over the fixed two-channel 4th-order crossover it adds:
  - a runtime-writable, double-buffered coefficient bank;
  - a state clear;
  - overrun detection;
  - optional saturation.

Parameters:
- DATA_NBITS, 24: sample width, signed two's complement.
- COEFF_NBITS, 40: coefficient width, signed 4.36 fixed point.
- COEFF_FBITS, 36: coefficient fractional bits.
- ACCUM_NBITS, 72: accumulator width. Must be at least DATA_NBITS+COEFF_NBITS+3.
- NUM_CH, 2: channels processed per sample period.
- NUM_STAGES, 2: biquads per band. Filter order is 2*NUM_STAGES.
- CADDR_NBITS, 5: coefficient address width. Must satisfy 2^CADDR_NBITS >= 10*NUM_STAGES.

Ports:
- i_mck  in  1  master clock; all logic on rising edge.
- i_rst  in  1  synchronous active-high reset.
- i_data  in  NUM_CH*DATA_NBITS  input samples; channel c in bits [c*DATA_NBITS +: DATA_NBITS].
- i_sample_valid  in  1  one-cycle strobe; i_data valid.
- o_lpf  out  NUM_CH*DATA_NBITS  LPF outputs, same packing as i_data.
- o_hpf  out  NUM_CH*DATA_NBITS  HPF outputs, same packing as i_data.
- o_sample_valid  out  1  one-cycle strobe; o_lpf/o_hpf updated.
- o_busy  out  1  high from sample acceptance until the o_sample_valid cycle inclusive.
- o_overrun  out  1  sticky; a sample arrived while busy.
- i_coeff_we  in  1  shadow bank write enable.
- i_coeff_addr  in  CADDR_NBITS  shadow write address.
- i_coeff_data  in  COEFF_NBITS  shadow write data.
- i_coeff_commit  in  1  pulse; request copy of shadow bank to active bank.
- i_clear_state  in  1  pulse; request zeroing of all delay registers.

Behaviour:
- Reset: all outputs, every delay register, both coefficient banks, and the pending-commit and pending-clear flags go to 0. FSM goes to IDLE.
- Coefficient address: (band*NUM_STAGES + stage)*5 + k.
  - band: 0=HPF, 1=LPF.
  - k: 0=b0, 1=b1, 2=b2, 3=a1, 4=a2.
  - Writes to addresses >= 10*NUM_STAGES are ignored.
- Shadow writes: accepted on any cycle, including while busy. The datapath reads only the active bank.
- Commit:
  - i_coeff_commit sets pending_commit.
  - The copy executes on the first clock edge at which the FSM is in IDLE.
  - If pending_commit and i_sample_valid coincide in IDLE, the copy and the acceptance happen on the same edge. That sample uses the new coefficients.
- Clear: i_clear_state sets pending_clear, which is applied like commit. If it coincides with acceptance, the sample is filtered from zero state.
- Processing order: for each channel c (0..NUM_CH-1), HPF stages 0..NUM_STAGES-1, then LPF stages 0..NUM_STAGES-1.
  - Stage 0 input is the channel sample.
  - Stage s>0 input is the output of stage s-1 of the same band.
- Biquad, 7 cycles:
  - LOAD: multiplier takes (x, b0).
  - MAC1..MAC5: each cycle folds the previous product into the accumulator and loads the next product. Products are x*b0, x1*b1, x2*b2, y1*a1, y2*a2. The b-products are added; the a-products are subtracted. MAC1 initialises acc = x*b0.
  - STORE: y = resize(acc >>> COEFF_FBITS). Then y2<=y1, y1<=y, x2<=x1, x1<=x.
  - Every channel/band/stage has its own x1, x2, y1, y2.
- Resize (saturation feature absent): y = {sign bit of the shifted accumulator, low DATA_NBITS-1 bits}. Overflow wraps.
- Multiply is combinational, sign-extended to ACCUM_NBITS.
- Latency:
  - Acceptance is an IDLE edge with i_sample_valid=1.
  - o_sample_valid is high exactly in cycle L = 14*NUM_CH*NUM_STAGES + 1 after acceptance; 57 at defaults.
  - o_lpf/o_hpf for all channels update together on that edge and hold until the next update.
  - o_busy falls on the edge after o_sample_valid; the FSM is in IDLE.
- Overrun: i_sample_valid while o_busy=1 is dropped and sets o_overrun. Only i_rst clears it.
- Reset mid-operation: aborts immediately. No o_sample_valid is issued and all state is zeroed.

Optional Feature:
- Macro: XOVER_SAT_EN.
- Defined: the resize clamps acc >>> COEFF_FBITS to [-2^(DATA_NBITS-1), 2^(DATA_NBITS-1)-1]. Defaults: 0x800000 / 0x7FFFFF.
  - Each clamp event sets sticky output o_sat (1 bit, reset 0, cleared only by i_rst).
  - Clamped values are also what the y1/y2 feedback registers store.
- Undefined: wrap behaviour as above; the o_sat port does not exist.

Test Plan:
- Passthrough: write b0=0x1000000000 (1.0) with all other coefficients 0 for every stage, then commit. i_data ch0=0x100000, ch1=0xF00000 -> o_lpf = o_hpf = input, o_sample_valid in cycle 57, o_busy high for cycles 0..57.
- Gain: b0=0x0800000000 (0.5) per stage, input 0x200000 -> all outputs 0x080000. Next sample 0 -> outputs 0.
- Feedback: stage 0 b0=1.0, a1=0xF000000000 (-1.0); later stages passthrough. Impulse 0x010000 then zeros -> outputs 0x010000 on every sample (integrator). i_clear_state in IDLE -> next output 0.
- Commit timing: shadow writes during busy plus commit mid-sample -> current sample uses old coefficients. The commit applies at IDLE. A commit coinciding with valid uses the new coefficients.
- Overrun: second i_sample_valid at cycle 10 -> ignored, o_overrun=1. Outputs match the single-sample result. o_overrun stays 1 until i_rst.
- Saturation (XOVER_SAT_EN): b0=0x4000000000 (4.0), input 0x300000 -> output 0x7FFFFF, o_sat=1. Without the macro, output wraps to 0x400000.
